// File: rtl/ascon_ps_serial.sv
// Ascon substitution layer (p_C + p_S), column-serial.
// Captures the 320-bit state, adds the round constant to x2[7:0], then runs
// the 64 five-bit columns through NB_SBOX parallel Sboxes, NB_SBOX columns
// per cycle, writing the results back in place.
//
// Ports:
//   clk          system clock, rising edge
//   rst          synchronous active-high reset
//   start        one-cycle request; samples state_in and round_const in IDLE
//   round_const  round constant XORed into x2[7:0] at capture
//   state_in     {x0, x1, x2, x3, x4}, x0 in [319:256]
//   busy         high while columns are being substituted
//   done         one-cycle pulse; state_out valid from this cycle on
//   state_out    substituted state, same packing as state_in

// Ascon 5-bit Sbox, purely combinational; i_x[4] is the x0 bit.
// Ports:
//   i_x  column value {x0, x1, x2, x3, x4}
//   o_y  substituted column, same bit order
module ascon_sbox (
   input  logic [4:0] i_x,
   output logic [4:0] o_y
);
   always_comb begin
      o_y = 5'h00;
      case (i_x)
         5'h00: o_y = 5'h04;  5'h01: o_y = 5'h0b;  5'h02: o_y = 5'h1f;  5'h03: o_y = 5'h14;
         5'h04: o_y = 5'h1a;  5'h05: o_y = 5'h15;  5'h06: o_y = 5'h09;  5'h07: o_y = 5'h02;
         5'h08: o_y = 5'h1b;  5'h09: o_y = 5'h05;  5'h0a: o_y = 5'h08;  5'h0b: o_y = 5'h12;
         5'h0c: o_y = 5'h1d;  5'h0d: o_y = 5'h03;  5'h0e: o_y = 5'h06;  5'h0f: o_y = 5'h1c;
         5'h10: o_y = 5'h1e;  5'h11: o_y = 5'h13;  5'h12: o_y = 5'h07;  5'h13: o_y = 5'h0e;
         5'h14: o_y = 5'h00;  5'h15: o_y = 5'h0d;  5'h16: o_y = 5'h11;  5'h17: o_y = 5'h18;
         5'h18: o_y = 5'h10;  5'h19: o_y = 5'h0c;  5'h1a: o_y = 5'h01;  5'h1b: o_y = 5'h19;
         5'h1c: o_y = 5'h16;  5'h1d: o_y = 5'h0a;  5'h1e: o_y = 5'h0f;  5'h1f: o_y = 5'h17;
         default: o_y = 5'h00;
      endcase
   end
endmodule

module ascon_ps_serial #(
   parameter int unsigned NB_SBOX = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [7:0]   round_const,
   input  logic [319:0] state_in,
   output logic         busy,
   output logic         done,
   output logic [319:0] state_out
);
   localparam int unsigned NB_CYC = 64 / NB_SBOX;
   localparam int unsigned CNT_W  = (NB_CYC > 1) ? $clog2(NB_CYC) : 1;

   typedef enum logic [1:0] {S_IDLE, S_PROC, S_DONE} fsm_t;

   fsm_t                    r_fsm,  w_fsm_nxt;
   logic [CNT_W-1:0]        r_cnt,  w_cnt_nxt;
   logic [4:0][63:0]        r_x,    w_x_nxt;    // [4]=x0 ... [0]=x4
   logic                    r_busy, w_busy_nxt;
   logic                    r_done, w_done_nxt;

   logic [5:0]              w_idx    [NB_SBOX];
   logic [4:0]              w_sb_in  [NB_SBOX];
   logic [4:0]              w_sb_out [NB_SBOX];

   // Column gather: slot k handles column cnt*NB_SBOX + k.
   always_comb begin
      for (int k = 0; k < NB_SBOX; k++) begin
         w_idx[k]   = 6'(7'(r_cnt) * 7'(NB_SBOX) + 7'(k));
         w_sb_in[k] = {r_x[4][w_idx[k]], r_x[3][w_idx[k]], r_x[2][w_idx[k]],
                       r_x[1][w_idx[k]], r_x[0][w_idx[k]]};
      end
   end

   for (genvar g = 0; g < NB_SBOX; g++) begin : g_sbox
      ascon_sbox u_sbox (
         .i_x (w_sb_in[g]),
         .o_y (w_sb_out[g])
      );
   end

   // Next-state, counter and in-place column write-back.
   always_comb begin
      w_fsm_nxt = r_fsm;
      w_cnt_nxt = r_cnt;
      w_x_nxt   = r_x;
      case (r_fsm)
         S_IDLE: begin
            if (start) begin
               w_x_nxt         = state_in;
               w_x_nxt[2][7:0] = state_in[135:128] ^ round_const;
               w_cnt_nxt       = '0;
               w_fsm_nxt       = S_PROC;
            end
         end
         S_PROC: begin
            for (int k = 0; k < NB_SBOX; k++) begin
               w_x_nxt[4][w_idx[k]] = w_sb_out[k][4];
               w_x_nxt[3][w_idx[k]] = w_sb_out[k][3];
               w_x_nxt[2][w_idx[k]] = w_sb_out[k][2];
               w_x_nxt[1][w_idx[k]] = w_sb_out[k][1];
               w_x_nxt[0][w_idx[k]] = w_sb_out[k][0];
            end
            if (r_cnt == CNT_W'(NB_CYC - 1)) begin
               w_cnt_nxt = '0;
               w_fsm_nxt = S_DONE;
            end else begin
               w_cnt_nxt = r_cnt + CNT_W'(1);
            end
         end
         S_DONE:  w_fsm_nxt = S_IDLE;
         default: w_fsm_nxt = S_IDLE;
      endcase
      w_busy_nxt = (w_fsm_nxt == S_PROC);
      w_done_nxt = (w_fsm_nxt == S_DONE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_fsm  <= S_IDLE;
         r_cnt  <= '0;
         r_x    <= '0;
         r_busy <= 1'b0;
         r_done <= 1'b0;
      end else begin
         r_fsm  <= w_fsm_nxt;
         r_cnt  <= w_cnt_nxt;
         r_x    <= w_x_nxt;
         r_busy <= w_busy_nxt;
         r_done <= w_done_nxt;
      end
   end

   assign busy      = r_busy;
   assign done      = r_done;
   assign state_out = r_x;

endmodule

// File: tb/tb_ascon_ps_serial.sv
// Bench for ascon_ps_serial: three instances (NB_SBOX = 8, 1, 64) share one
// stimulus stream; each has its own expected-result queue and idle model.
module tb_ascon_ps_serial;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         rst, start;
   logic [7:0]   rc;
   logic [319:0] st_in;
   logic         busy8, done8, busy1, done1, busy64, done64;
   logic [319:0] so8, so1, so64;

   ascon_ps_serial #(.NB_SBOX(8)) u_dut8 (
      .clk(clk), .rst(rst), .start(start), .round_const(rc), .state_in(st_in),
      .busy(busy8), .done(done8), .state_out(so8));
   ascon_ps_serial #(.NB_SBOX(1)) u_dut1 (
      .clk(clk), .rst(rst), .start(start), .round_const(rc), .state_in(st_in),
      .busy(busy1), .done(done1), .state_out(so1));
   ascon_ps_serial #(.NB_SBOX(64)) u_dut64 (
      .clk(clk), .rst(rst), .start(start), .round_const(rc), .state_in(st_in),
      .busy(busy64), .done(done64), .state_out(so64));

   typedef struct {
      logic [319:0] st;
      int unsigned  scyc;
   } exp_t;

   typedef struct {
      logic [319:0] st;
      logic [7:0]   c;
      logic [319:0] ex;
   } vec_t;

   exp_t        q8[$], q1[$], q64[$];
   int unsigned free_c[3];
   int unsigned cyc = 0;
   int          n_assert = 0;
   int          n_fail = 0;
   vec_t        vt[4];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [319:0] got, input logic [319:0] exp);
      n_assert++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   // Bit-sliced reference of p_C followed by p_S.
   function automatic logic [319:0] model(input logic [319:0] s, input logic [7:0] c);
      logic [63:0] x0, x1, x2, x3, x4, t0, t1, t2, t3, t4;
      x0 = s[319:256]; x1 = s[255:192]; x2 = s[191:128] ^ {56'd0, c};
      x3 = s[127:64];  x4 = s[63:0];
      x0 ^= x4; x4 ^= x3; x2 ^= x1;
      t0 = ~x0 & x1; t1 = ~x1 & x2; t2 = ~x2 & x3; t3 = ~x3 & x4; t4 = ~x4 & x0;
      x0 ^= t1; x1 ^= t2; x2 ^= t3; x3 ^= t4; x4 ^= t0;
      x1 ^= x0; x0 ^= x4; x3 ^= x2; x2 = ~x2;
      return {x0, x1, x2, x3, x4};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Drive one start; queue an expectation for each instance that is idle.
   task automatic do_start(input logic [319:0] s, input logic [7:0] c, input logic [319:0] ex);
      exp_t e;
      st_in = s; rc = c; start = 1'b1;
      e.st = ex; e.scyc = cyc;
      if (cyc >= free_c[0]) begin q8.push_back(e);  free_c[0] = cyc + 10; end
      if (cyc >= free_c[1]) begin q1.push_back(e);  free_c[1] = cyc + 66; end
      if (cyc >= free_c[2]) begin q64.push_back(e); free_c[2] = cyc + 3;  end
      step();
      start = 1'b0;
   endtask

   task automatic wait_q(input bit all, input int unsigned bound);
      int unsigned n = 0;
      while (((q8.size() + q64.size() + (all ? q1.size() : 0)) != 0) && n < bound) begin
         step();
         n++;
      end
      if (n >= bound) begin
         chk("drain timeout pending", 320'(q8.size() + q1.size() + q64.size()), 320'(0));
         q8.delete(); q1.delete(); q64.delete();
         free_c[0] = 0; free_c[1] = 0; free_c[2] = 0;
      end
   endtask

   function automatic logic [319:0] rnd320();
      return {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(),
              $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
   endfunction

   // Scoreboard: every done must match the oldest queued expectation.
   always @(negedge clk) begin
      exp_t e;
      if (done8) begin
         if (q8.size() == 0) chk("dut8 done without request", 320'(done8), 320'(0));
         else begin
            e = q8.pop_front();
            chk("dut8 state_out", so8, e.st);
            chk("dut8 latency", 320'(cyc - e.scyc), 320'(9));
         end
      end
      if (done1) begin
         if (q1.size() == 0) chk("dut1 done without request", 320'(done1), 320'(0));
         else begin
            e = q1.pop_front();
            chk("dut1 state_out", so1, e.st);
            chk("dut1 latency", 320'(cyc - e.scyc), 320'(65));
         end
      end
      if (done64) begin
         if (q64.size() == 0) chk("dut64 done without request", 320'(done64), 320'(0));
         else begin
            e = q64.pop_front();
            chk("dut64 state_out", so64, e.st);
            chk("dut64 latency", 320'(cyc - e.scyc), 320'(2));
         end
      end
   end

   initial begin
      logic [319:0] s;
      logic [7:0]   c;
      vt[0] = '{st: '0, c: 8'h00,
                ex: {64'h0, 64'h0, 64'hFFFFFFFFFFFFFFFF, 64'h0, 64'h0}};
      vt[1] = '{st: '0, c: 8'hF0,
                ex: {64'hF0, 64'hF0, 64'hFFFFFFFFFFFFFF0F, 64'hF0, 64'h0}};
      vt[2] = '{st: {320{1'b1}}, c: 8'h00,
                ex: {64'hFFFFFFFFFFFFFFFF, 64'h0, 64'hFFFFFFFFFFFFFFFF,
                     64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF}};
      vt[3] = '{st: {320{1'b1}}, c: 8'hFF,
                ex: {64'hFFFFFFFFFFFFFFFF, 64'hFF, 64'hFFFFFFFFFFFFFF00,
                     64'hFFFFFFFFFFFFFF00, 64'hFFFFFFFFFFFFFFFF}};
      free_c[0] = 0; free_c[1] = 0; free_c[2] = 0;

      rst = 1'b1; start = 1'b0; st_in = '0; rc = '0;
      repeat (2) step();
      chk("reset busy", 320'({busy8, busy1, busy64}), 320'(0));
      chk("reset done", 320'({done8, done1, done64}), 320'(0));
      chk("reset state8", so8, '0);
      chk("reset state1", so1, '0);
      chk("reset state64", so64, '0);
      rst = 1'b0;
      step();

      // Zero state: cycle-exact busy/done on the 8-Sbox instance.
      do_start(vt[0].st, vt[0].c, vt[0].ex);
      for (int k = 1; k <= 8; k++) begin
         chk($sformatf("busy cycle %0d", k), 320'(busy8), 320'(1));
         chk($sformatf("done cycle %0d", k), 320'(done8), 320'(0));
         step();
      end
      chk("done at cycle 9", 320'(done8), 320'(1));
      chk("busy at cycle 9", 320'(busy8), 320'(0));
      step();
      chk("done single pulse", 320'(done8), 320'(0));
      wait_q(1'b1, 200);

      for (int i = 1; i < 4; i++) begin
         do_start(vt[i].st, vt[i].c, vt[i].ex);
         wait_q(1'b1, 200);
      end

      // Re-asserted start while busy is ignored (the 64-Sbox instance is
      // already idle again and legitimately accepts both).
      s = rnd320(); c = 8'($urandom());
      do_start(s, c, model(s, c));
      repeat (2) step();
      do_start(s, c, model(s, c));
      repeat (4) step();
      do_start(s, c, model(s, c));
      wait_q(1'b1, 200);

      // Reset together with start mid-run aborts without a done.
      s = rnd320(); c = 8'($urandom());
      do_start(s, c, model(s, c));
      repeat (3) step();
      rst = 1'b1; start = 1'b1;
      step();
      rst = 1'b0; start = 1'b0;
      chk("abort busy", 320'({busy8, busy1, busy64}), 320'(0));
      chk("abort done", 320'({done8, done1, done64}), 320'(0));
      chk("abort state8", so8, '0);
      chk("abort state1", so1, '0);
      q8.delete(); q1.delete(); q64.delete();
      free_c[0] = 0; free_c[1] = 0; free_c[2] = 0;
      repeat (70) step();
      do_start(vt[3].st, vt[3].c, vt[3].ex);
      wait_q(1'b1, 200);

      for (int r = 0; r < 1000; r++) begin
         s = rnd320(); c = 8'($urandom());
         do_start(s, c, model(s, c));
         wait_q(1'b0, 50);
      end
      wait_q(1'b1, 200);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
